// File: rtl/ifu_pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: pc_src codes, FSM states, defaults.
package ifu_pc_fetch_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned CNT_W_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    // Same encoding the branch-resolution block drives; 2'b11 is reserved and behaves as SEQ.
    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_JAL  = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_EXEC = 2'b10,
        S_HALT = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/ifu_pc_fetch_pc_target.sv
// Combinational next-PC selection and alignment check for the fetch unit.
module ifu_pc_fetch_pc_target
    import ifu_pc_fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [1:0]      pc_src,
    output logic [XLEN-1:0] next_pc_c,
    output logic            misaligned_c
);

    // jalr clears only bit 0; a set bit 1 survives and is reported as misaligned.
    always_comb begin
        next_pc_c = pc + XLEN'(4);
        case (pc_src)
            PC_SRC_SEQ:  next_pc_c = pc + XLEN'(4);
            PC_SRC_JAL:  next_pc_c = pc + imm;
            PC_SRC_JALR: next_pc_c = (rs1 + imm) & ~XLEN'(1);
            default:     next_pc_c = pc + XLEN'(4);
        endcase
        misaligned_c = |next_pc_c[1:0];
    end

endmodule

// File: rtl/ifu_pc_fetch.sv
// Architectural PC holder and fetch sequencer: REQ -> WAIT -> EXEC per instruction, sticky HALT.
module ifu_pc_fetch
    import ifu_pc_fetch_pkg::*;
#(
    parameter int unsigned    XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int unsigned    CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pc_src,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic             exe_done,
    input  logic             halt_req,
    output logic             req_valid,
    output logic [XLEN-1:0]  req_addr,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [31:0]      rsp_data,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retire_cnt
);

    fetch_state_e    state;
    logic [XLEN-1:0] next_pc_c;
    logic            misaligned_c;

    ifu_pc_fetch_pc_target #(
        .XLEN (XLEN)
    ) u_pc_target (
        .pc           (pc),
        .imm          (imm),
        .rs1          (rs1),
        .pc_src       (pc_src),
        .next_pc_c    (next_pc_c),
        .misaligned_c (misaligned_c)
    );

    assign req_addr = pc;

    // State and the Moore flags are updated together so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            inst         <= 32'd0;
            inst_valid   <= 1'b0;
            req_valid    <= 1'b1;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            retire_cnt   <= CNT_W'(0);
        end else begin
            case (state)
                S_REQ: begin
                    if (req_ready) begin
                        state     <= S_WAIT;
                        req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        state      <= S_EXEC;
                        inst       <= rsp_data;
                        inst_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exe_done) begin
                        inst_valid <= 1'b0;
                        if (halt_req) begin
                            state      <= S_HALT;
                            halted     <= 1'b1;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                        end else if (misaligned_c) begin
                            state        <= S_HALT;
                            halted       <= 1'b1;
                            misalign_err <= 1'b1;
                        end else begin
                            state      <= S_REQ;
                            req_valid  <= 1'b1;
                            pc         <= next_pc_c;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed bench for ifu_pc_fetch: instruction table plus hand sequences for reset/stall/halt corners.
module tb_ifu_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        exe_done;
    logic        halt_req;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_pc_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_src       (pc_src),
        .imm          (imm),
        .rs1          (rs1),
        .exe_done     (exe_done),
        .halt_req     (halt_req),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .pc           (pc),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .halted       (halted),
        .misalign_err (misalign_err),
        .retire_cnt   (retire_cnt)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic        exp_halted;
        logic        exp_mis;
        logic        exp_req;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a request, then a zero-wait handshake and response.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        for (int i = 0; i < 20; i++) begin
            if (req_valid === 1'b1) break;
            step();
        end
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr", req_addr, exp_addr);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = data;
        step();
        rsp_valid = 1'b0;
        chk("exec_inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, data);
    endtask

    task automatic do_exec(input logic [1:0] src, input logic [31:0] im, input logic [31:0] r1,
                           input logic hr);
        pc_src   = src;
        imm      = im;
        rs1      = r1;
        halt_req = hr;
        exe_done = 1'b1;
        step();
        exe_done = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;

        tbl[0] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h8000_0004, 32'd1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{2'b11, 32'h0000_0100, 32'h0000_0200, 32'h8000_0008, 32'd2, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{2'b01, 32'h0000_0008, 32'h0000_0000, 32'h8000_0010, 32'd3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{2'b01, 32'hFFFF_FFF8, 32'h0000_0000, 32'h8000_0008, 32'd4, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'b10, 32'h0000_0001, 32'h8000_1003, 32'h8000_1004, 32'd5, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{2'b10, 32'h0000_0005, 32'h8000_0000, 32'h8000_0004, 32'd6, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'd7, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'd8, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'd9, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{2'b10, 32'h0000_0001, 32'h8000_0001, 32'h0000_0000, 32'd9, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; pc_src = 2'b00; imm = '0; rs1 = '0; exe_done = 1'b0; halt_req = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_halted", 32'({halted, misalign_err, inst_valid}), 32'd0);

        exp_pc = 32'h8000_0000;
        for (int i = 0; i < 10; i++) begin
            do_fetch(exp_pc, 32'h0000_0013 | (32'(i) << 20));
            do_exec(tbl[i].src, tbl[i].imm, tbl[i].rs1, 1'b0);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("v%0d_cnt", i), retire_cnt, tbl[i].exp_cnt);
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].exp_halted));
            chk($sformatf("v%0d_mis", i), 32'(misalign_err), 32'(tbl[i].exp_mis));
            chk($sformatf("v%0d_req", i), 32'(req_valid), 32'(tbl[i].exp_req));
            chk($sformatf("v%0d_ivalid", i), 32'(inst_valid), 32'd0);
            exp_pc = tbl[i].exp_pc;
        end

        // Halt is absorbing: every input is ignored.
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; exe_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_req_valid", 32'(req_valid), 32'd0);
            chk("halt_inst_valid", 32'(inst_valid), 32'd0);
            chk("halt_pc", pc, 32'h0000_0000);
            chk("halt_sticky", 32'({halted, misalign_err}), 32'd3);
        end
        req_ready = 1'b0; rsp_valid = 1'b0; exe_done = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_flags", 32'({halted, misalign_err}), 32'd0);
        chk("rst2_cnt", retire_cnt, 32'd0);
        do_fetch(32'h8000_0000, 32'h0010_0093);
        do_exec(2'b00, 32'd0, 32'd0, 1'b0);
        chk("seq_cnt", retire_cnt, 32'd1);
        chk("seq_pc", pc, 32'h8000_0004);

        // Reset in the middle of a fetch abandons it immediately.
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_pc", pc, 32'h8000_0000);
        chk("async_cnt", retire_cnt, 32'd0);
        chk("async_req", 32'(req_valid), 32'd1);
        step();
        rst = 1'b0;

        // Stalled request with a stale response: request held, response ignored.
        rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_valid", 32'(req_valid), 32'd1);
            chk("stall_req_addr", req_addr, 32'h8000_0000);
            chk("stall_ivalid", 32'(inst_valid), 32'd0);
            step();
        end
        rsp_valid = 1'b0;
        chk("stall_inst", inst, 32'd0);

        do_fetch(32'h8000_0000, 32'h0000_0073);
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1; rsp_data = 32'hCAFE_0000 | 32'(i);
            step();
            chk("exec_hold_inst", inst, 32'h0000_0073);
            chk("exec_hold_ivalid", 32'(inst_valid), 32'd1);
            chk("exec_hold_req", 32'(req_valid), 32'd0);
        end
        rsp_valid = 1'b0;

        // ebreak wins over a misaligned target and still retires.
        do_exec(2'b10, 32'h0000_0001, 32'h8000_0001, 1'b1);
        chk("ebreak_halted", 32'(halted), 32'd1);
        chk("ebreak_mis", 32'(misalign_err), 32'd0);
        chk("ebreak_cnt", retire_cnt, 32'd1);
        chk("ebreak_pc", pc, 32'h8000_0000);
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ebreak_no_req", 32'(req_valid), 32'd0);
        end
        req_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
